// File: rtl/mem_responder.sv
// Memory-side responder for the mem_intf read/write protocol: DEPTH-word store
// with a post-reset init sweep and protocol error reporting. Optional parity: MEM_RESP_PARITY_EN.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  protocol_err,
  output logic [7:0]            err_count,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    protocol_err_q, protocol_err_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_acc;

  // Next-state, array write port and registered outputs
  always_comb begin
    state_d        = state_q;
    init_ptr_d     = init_ptr_q;
    data_out_d     = data_out_q;
    ready_d        = ready_q;
    protocol_err_d = 1'b0;
    err_count_d    = err_count_q;
    mem_we         = 1'b0;
    mem_waddr      = addr;
    mem_wdata      = data_in;
    rd_acc         = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = INIT_VALUE;
        init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
        if (init_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: begin
        if (read && write) begin
          protocol_err_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else if (write) begin
          mem_we = 1'b1;
        end else if (read) begin
          rd_acc     = 1'b1;
          data_out_d = mem_q[addr];
        end
      end
      default: begin
        state_d = S_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_INIT;
      init_ptr_q     <= '0;
      data_out_q     <= '0;
      ready_q        <= 1'b0;
      protocol_err_q <= 1'b0;
      err_count_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      init_ptr_q     <= init_ptr_d;
      data_out_q     <= data_out_d;
      ready_q        <= ready_d;
      protocol_err_q <= protocol_err_d;
      err_count_q    <= err_count_d;
    end
  end

  // Storage is deliberately not reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef MEM_RESP_PARITY_EN
  logic par_q [DEPTH];
  logic parity_err_q, parity_err_d;

  always_ff @(posedge clk) begin
    if (mem_we) par_q[mem_waddr] <= ^mem_wdata;
  end

  always_comb begin
    parity_err_d = rd_acc && ((^mem_q[addr]) != par_q[addr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out     = data_out_q;
  assign ready        = ready_q;
  assign protocol_err = protocol_err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed steps plus random traffic against a
// behavioural model tracking cycles-since-reset, word contents and counters.
module tb_mem_responder;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam logic [7:0]  INIT  = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          protocol_err;
  logic [7:0]    err_count;
  logic          parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] m_mem [DEPTH];
  logic       m_bad [DEPTH];
  int         m_cycles;
  logic [7:0] m_dout;
  logic [7:0] m_errc;
  logic       m_perr;
  logic       m_parerr;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready),
    .protocol_err(protocol_err), .err_count(err_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("ready", 32'(ready), 32'(m_cycles >= DEPTH));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    chk("err_count", 32'(err_count), 32'(m_errc));
    chk("parity_err", 32'(parity_err), 32'(m_parerr));
  endtask

  // Called at a negedge; drives, waits one posedge, updates model, checks.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    read = r; write = w; addr = a; data_in = d;
    @(posedge clk);
    m_perr   = 1'b0;
    m_parerr = 1'b0;
    if (m_cycles < DEPTH) begin
      m_mem[m_cycles] = INIT;
      m_bad[m_cycles] = 1'b0;
      m_cycles++;
    end else if (r && w) begin
      m_perr = 1'b1;
      if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    end else if (w) begin
      m_mem[a] = d;
      m_bad[a] = 1'b0;
    end else if (r) begin
      m_dout   = m_mem[a];
      m_parerr = m_bad[a];
    end
    #1;
    chk_model();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read = 1'b0; write = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    m_cycles = 0; m_dout = 8'h00; m_errc = 8'h00; m_perr = 1'b0; m_parerr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = INIT;
      m_bad[i] = 1'b0;
    end

    // 1: sweep length and first read
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b0, 1'b0, '0, '0);
    chk("t1_ready_low_31", 32'(ready), 32'd0);
    step(1'b0, 1'b0, '0, '0);
    chk("t1_ready_high_32", 32'(ready), 32'd1);
    step(1'b1, 1'b0, 5'h1F, '0);
    chk("t1_read_1f", 32'(data_out), 32'h00);

    // 2: write then read, value held across idles
    step(1'b0, 1'b1, 5'h03, 8'hA5);
    step(1'b1, 1'b0, 5'h03, '0);
    chk("t2_read_03", 32'(data_out), 32'hA5);
    idle(3);
    chk("t2_hold_03", 32'(data_out), 32'hA5);

    // 3: back-to-back write/read
    step(1'b0, 1'b1, 5'h1F, 8'h3C);
    step(1'b1, 1'b0, 5'h1F, '0);
    chk("t3_read_1f", 32'(data_out), 32'h3C);
    step(1'b1, 1'b0, 5'h00, '0);
    chk("t3_read_00", 32'(data_out), 32'h00);

    // 4: protocol violations and saturation
    step(1'b1, 1'b1, 5'h07, 8'hFF);
    chk("t4_perr_pulse", 32'(protocol_err), 32'd1);
    chk("t4_errc_1", 32'(err_count), 32'd1);
    chk("t4_dout_hold", 32'(data_out), 32'h00);
    idle(1);
    chk("t4_perr_clear", 32'(protocol_err), 32'd0);
    step(1'b1, 1'b0, 5'h07, '0);
    chk("t4_mem7_unchanged", 32'(data_out), 32'h00);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, AW'($urandom), DW'($urandom));
    chk("t4_errc_sat", 32'(err_count), 32'hFF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      step(op == 0 || (op >= 5 && op <= 8), op <= 4, AW'($urandom), DW'($urandom));
    end

    // 5: reset mid-sweep, write during INIT ignored
    do_reset();
    idle(10);
    do_reset();
    chk("t5_ready_low", 32'(ready), 32'd0);
    step(1'b0, 1'b1, 5'h14, 8'h55);
    idle(30);
    chk("t5_ready_low_31", 32'(ready), 32'd0);
    idle(1);
    chk("t5_ready_high", 32'(ready), 32'd1);
    step(1'b1, 1'b0, 5'h14, '0);
    chk("t5_init_write_ignored", 32'(data_out), 32'(INIT));

    // 6: parity
`ifdef MEM_RESP_PARITY_EN
    dut.par_q[2] = ~dut.par_q[2];
    m_bad[2] = 1'b1;
    step(1'b1, 1'b0, 5'h02, '0);
    chk("t6_parity_pulse", 32'(parity_err), 32'd1);
    idle(1);
    chk("t6_parity_clear", 32'(parity_err), 32'd0);
`else
    step(1'b1, 1'b0, 5'h02, '0);
    chk("t6_parity_tied", 32'(parity_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
